// File: rtl/int_regfile.sv
// Integer register file with per-register pending scoreboard for issue/writeback.
// Optional macro REGFILE_BYPASS_EN forwards same-cycle writeback data to the read ports.
package int_regfile_pkg;
  localparam int RF_NUM_REGS = 32;
  localparam int RF_XLEN     = 32;
  localparam int RF_IDX_W    = $clog2(RF_NUM_REGS);

  typedef logic [RF_XLEN-1:0] reg_data_t;

  typedef struct packed {
    logic                valid;
    logic [RF_IDX_W-1:0] idx;
    reg_data_t           data;
  } int_arch_reg_wb_t;
endpackage

module int_regfile #(
  parameter int NUM_REGS = int_regfile_pkg::RF_NUM_REGS,
  parameter int XLEN     = int_regfile_pkg::RF_XLEN,
  localparam int IDX_W   = $clog2(NUM_REGS),
  localparam int CNT_W   = IDX_W + 1
) (
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  int_regfile_pkg::int_arch_reg_wb_t i_wb,
  input  logic                             i_flush,
  input  logic [IDX_W-1:0]                 i_rs1_idx,
  input  logic [IDX_W-1:0]                 i_rs2_idx,
  output logic [XLEN-1:0]                  o_rs1_data,
  output logic [XLEN-1:0]                  o_rs2_data,
  output logic                             o_rs1_ready,
  output logic                             o_rs2_ready,
  input  logic                             i_issue_valid,
  input  logic [IDX_W-1:0]                 i_issue_rd_idx,
  output logic                             o_rd_ready,
  output logic [NUM_REGS-1:0]              o_pending,
  output logic [CNT_W-1:0]                 o_pending_count,
  input  logic [31:0]                      i_log_fd
);

  // Handshake: writeback is valid-only and always accepted; issue may assert
  // i_issue_valid only while o_rd_ready is high, otherwise the issue stage stalls.

  logic [XLEN-1:0]     regs [NUM_REGS];
  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                wb_we;
  logic                issue_set;

  assign wb_we     = i_wb.valid && (i_wb.idx != '0);
  assign issue_set = i_issue_valid && (i_issue_rd_idx != '0) && !i_flush;

  // Flush beats issue, and issue beats writeback clear on the same bit.
  always_comb begin
    pending_d = pending_q;
    if (i_flush) begin
      pending_d = '0;
    end else begin
      if (wb_we) pending_d[i_wb.idx] = 1'b0;
      if (issue_set) pending_d[i_issue_rd_idx] = 1'b1;
    end
    count_d = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      count_d = count_d + CNT_W'(pending_d[i]);
    end
  end

  // x0 is reset and never written, so its flops reduce to constants.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
      pending_q <= '0;
      count_q   <= '0;
    end else begin
      if (wb_we) regs[i_wb.idx] <= i_wb.data;
      pending_q <= pending_d;
      count_q   <= count_d;
    end
  end

  logic [IDX_W-1:0] rs_idx   [2];
  logic [XLEN-1:0]  rs_data  [2];
  logic             rs_ready [2];

  assign rs_idx[0] = i_rs1_idx;
  assign rs_idx[1] = i_rs2_idx;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      rs_data[p]  = '0;
      rs_ready[p] = 1'b1;
      if (rs_idx[p] != '0) begin
        rs_data[p]  = regs[rs_idx[p]];
        rs_ready[p] = ~pending_q[rs_idx[p]];
`ifdef REGFILE_BYPASS_EN
        if (wb_we && (i_wb.idx == rs_idx[p])) begin
          rs_data[p]  = i_wb.data;
          rs_ready[p] = 1'b1;
        end
`endif
      end
    end
  end

  always_comb begin
    o_rd_ready = 1'b1;
    if (i_issue_rd_idx != '0) begin
      o_rd_ready = ~pending_q[i_issue_rd_idx];
`ifdef REGFILE_BYPASS_EN
      if (wb_we && (i_wb.idx == i_issue_rd_idx)) o_rd_ready = 1'b1;
`endif
    end
  end

  assign o_rs1_data      = rs_data[0];
  assign o_rs2_data      = rs_data[1];
  assign o_rs1_ready     = rs_ready[0];
  assign o_rs2_ready     = rs_ready[1];
  assign o_pending       = pending_q;
  assign o_pending_count = count_q;

`ifndef SYNTHESIS
  // A retiring same-cycle writeback to rd frees the slot, so that case is legal.
  always @(posedge i_clk) begin
    if (i_rst_n) begin
      if (issue_set && pending_q[i_issue_rd_idx] &&
          !(wb_we && (i_wb.idx == i_issue_rd_idx))) begin
        assert (1'b0) else $error("int_regfile: issue to pending x%0d", i_issue_rd_idx);
      end
      if (i_log_fd != 32'd0) begin
        if (wb_we)
          $display("[RF ] write x%0d = %h pending=%0d", i_wb.idx, i_wb.data, count_d);
        if (i_flush)
          $display("[RF ] flush pending=%0d", count_d);
      end
    end
  end
`endif

endmodule

// File: tb/tb_int_regfile.sv
// Directed bench for int_regfile: drivers queue expectations, a negedge monitor checks them.
module tb_int_regfile;
  localparam int NR = 32;
  localparam int IW = 5;

  logic                              clk;
  logic                              rst_n;
  int_regfile_pkg::int_arch_reg_wb_t wb;
  logic                              flush;
  logic [IW-1:0]                     rs1_idx, rs2_idx, rd_idx;
  logic [31:0]                       rs1_data, rs2_data;
  logic                              rs1_ready, rs2_ready, rd_ready;
  logic                              issue_valid;
  logic [NR-1:0]                     pending;
  logic [IW:0]                       pending_count;

  int_regfile dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_wb            (wb),
    .i_flush         (flush),
    .i_rs1_idx       (rs1_idx),
    .i_rs2_idx       (rs2_idx),
    .o_rs1_data      (rs1_data),
    .o_rs2_data      (rs2_data),
    .o_rs1_ready     (rs1_ready),
    .o_rs2_ready     (rs2_ready),
    .i_issue_valid   (issue_valid),
    .i_issue_rd_idx  (rd_idx),
    .o_rd_ready      (rd_ready),
    .o_pending       (pending),
    .o_pending_count (pending_count),
    .i_log_fd        (32'd0)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // scoreboard
  localparam int S_RS1D = 0, S_RS1R = 1, S_RS2D = 2, S_RS2R = 3, S_RDR = 4, S_PEND = 5, S_CNT = 6;
  logic [31:0] exp_q [$];
  int          sel_q [$];
  string       name_q [$];
  int          n_checks = 0;
  int          n_pass   = 0;

  function automatic logic [31:0] actual(input int sel);
    case (sel)
      S_RS1D:  return rs1_data;
      S_RS1R:  return {31'd0, rs1_ready};
      S_RS2D:  return rs2_data;
      S_RS2R:  return {31'd0, rs2_ready};
      S_RDR:   return {31'd0, rd_ready};
      S_PEND:  return pending;
      default: return {26'd0, pending_count};
    endcase
  endfunction

  always @(negedge clk) begin
    while (exp_q.size() > 0) begin
      logic [31:0] e, a;
      int          s;
      string       n;
      e = exp_q.pop_front();
      s = sel_q.pop_front();
      n = name_q.pop_front();
      a = actual(s);
      n_checks++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %h expected %h @%0t", n, a, e, $time);
    end
  end

  // driver tasks
  task automatic expect_val(input int sel, input logic [31:0] e, input string name);
    exp_q.push_back(e);
    sel_q.push_back(sel);
    name_q.push_back(name);
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
    wb          = '0;
    flush       = 1'b0;
    issue_valid = 1'b0;
    rd_idx      = '0;
  endtask

  task automatic drive_wb(input logic [IW-1:0] idx, input logic [31:0] d);
    wb.valid = 1'b1;
    wb.idx   = idx;
    wb.data  = d;
  endtask

  task automatic drive_issue(input logic [IW-1:0] rd);
    issue_valid = 1'b1;
    rd_idx      = rd;
  endtask

  task automatic read(input logic [IW-1:0] a, input logic [IW-1:0] b);
    rs1_idx = a;
    rs2_idx = b;
  endtask

  initial begin
    rst_n = 1'b0;
    wb = '0; flush = 1'b0; issue_valid = 1'b0; rd_idx = '0;
    rs1_idx = '0; rs2_idx = '0;

    // during reset
    cycle();
    expect_val(S_PEND, 32'd0, "rst_pending");
    expect_val(S_CNT, 32'd0, "rst_count");
    expect_val(S_RS1R, 32'd1, "rst_rs1_ready");
    cycle();
    rst_n = 1'b1;

    // all registers read zero / ready on both ports
    for (int i = 0; i < NR; i++) begin
      cycle();
      read(IW'(i), IW'(NR - 1 - i));
      expect_val(S_RS1D, 32'd0, "init_rs1_data");
      expect_val(S_RS1R, 32'd1, "init_rs1_ready");
      expect_val(S_RS2D, 32'd0, "init_rs2_data");
      expect_val(S_RS2R, 32'd1, "init_rs2_ready");
    end
    expect_val(S_CNT, 32'd0, "init_count");

    // issue x5, writeback DEADBEEF two cycles later
    cycle(); drive_issue(5); read(5, 0);
    expect_val(S_RDR, 32'd1, "x5_rd_ready_free");
    expect_val(S_RS1R, 32'd1, "x5_ready_issue_cycle");
    cycle(); read(5, 0);
    expect_val(S_RS1R, 32'd0, "x5_ready_after_issue");
    expect_val(S_PEND, 32'h0000_0020, "x5_pending");
    expect_val(S_CNT, 32'd1, "x5_count");
    cycle(); drive_wb(5, 32'hDEADBEEF); read(5, 0);
`ifdef REGFILE_BYPASS_EN
    expect_val(S_RS1D, 32'hDEADBEEF, "x5_bypass_data");
    expect_val(S_RS1R, 32'd1, "x5_bypass_ready");
`else
    expect_val(S_RS1D, 32'd0, "x5_wb_cycle_data");
    expect_val(S_RS1R, 32'd0, "x5_wb_cycle_ready");
`endif
    cycle(); read(5, 0);
    expect_val(S_RS1D, 32'hDEADBEEF, "x5_data");
    expect_val(S_RS1R, 32'd1, "x5_ready");
    expect_val(S_CNT, 32'd0, "x5_count_clear");

    // x0 ignores writes and reservations
    cycle(); drive_wb(0, 32'h1234); read(0, 0);
    expect_val(S_RS1D, 32'd0, "x0_wb_cycle");
    cycle(); drive_issue(0); read(0, 0);
    expect_val(S_RS1D, 32'd0, "x0_data");
    expect_val(S_RS1R, 32'd1, "x0_ready");
    expect_val(S_RDR, 32'd1, "x0_rd_ready");
    cycle();
    expect_val(S_PEND, 32'd0, "x0_pending");
    expect_val(S_CNT, 32'd0, "x0_count");

    // flush with same-cycle writeback and dropped issue
    cycle(); drive_wb(3, 32'd33);
    cycle(); drive_wb(9, 32'd99);
    cycle(); drive_issue(3); expect_val(S_RDR, 32'd1, "x3_rd_ready");
    cycle(); drive_issue(7); expect_val(S_RDR, 32'd1, "x7_rd_ready");
    cycle(); drive_issue(9); expect_val(S_RDR, 32'd1, "x9_rd_ready");
    cycle(); flush = 1'b1; drive_wb(7, 32'h55); drive_issue(12); read(3, 9);
    expect_val(S_CNT, 32'd3, "preflush_count");
    expect_val(S_PEND, 32'h0000_0288, "preflush_pending");
    expect_val(S_RS1R, 32'd0, "preflush_x3_ready");
    expect_val(S_RS2D, 32'd99, "preflush_x9_data");
    cycle(); read(7, 3);
    expect_val(S_PEND, 32'd0, "flush_pending");
    expect_val(S_CNT, 32'd0, "flush_count");
    expect_val(S_RS1D, 32'h55, "flush_x7_data");
    expect_val(S_RS1R, 32'd1, "flush_x7_ready");
    expect_val(S_RS2D, 32'd33, "flush_x3_data");
    expect_val(S_RS2R, 32'd1, "flush_x3_ready");
    cycle(); read(9, 12);
    expect_val(S_RS1D, 32'd99, "flush_x9_data");
    expect_val(S_RS2R, 32'd1, "flush_x12_dropped");

    // same-cycle issue and writeback to pending x4
    cycle(); drive_issue(4);
    cycle(); drive_issue(4); drive_wb(4, 32'hA);
    expect_val(S_PEND, 32'h0000_0010, "x4_pending_before");
`ifdef REGFILE_BYPASS_EN
    expect_val(S_RDR, 32'd1, "x4_rd_ready_bypass");
`else
    expect_val(S_RDR, 32'd0, "x4_rd_ready_busy");
`endif
    cycle(); read(4, 0);
    expect_val(S_RS1D, 32'hA, "x4_data");
    expect_val(S_RS1R, 32'd0, "x4_still_pending");
    expect_val(S_PEND, 32'h0000_0010, "x4_pending_after");
    expect_val(S_CNT, 32'd1, "x4_count");
    cycle(); drive_wb(4, 32'hB);
    cycle();
    expect_val(S_CNT, 32'd0, "x4_retired");

    // async reset with four reservations outstanding
    cycle(); drive_issue(1);
    cycle(); drive_issue(2);
    cycle(); drive_issue(6);
    cycle(); drive_issue(8);
    cycle(); read(8, 3);
    expect_val(S_CNT, 32'd4, "prereset_count");
    expect_val(S_PEND, 32'h0000_0146, "prereset_pending");
    cycle(); drive_issue(10); read(8, 3);
    rst_n = 1'b0;
    expect_val(S_PEND, 32'd0, "async_rst_pending");
    expect_val(S_CNT, 32'd0, "async_rst_count");
    expect_val(S_RS2D, 32'd0, "async_rst_x3_data");
    expect_val(S_RS1R, 32'd1, "async_rst_x8_ready");
    cycle();
    rst_n = 1'b1;
    cycle(); read(3, 10);
    expect_val(S_RS1D, 32'd0, "post_rst_x3_data");
    expect_val(S_RS2R, 32'd1, "post_rst_x10_ready");

    cycle();
    cycle();
    n_checks++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL drain: got %0d queued expected 0", exp_q.size());
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1, "timeout");
  end
endmodule
